aibcr3_dcc_code_ctrl: RTL
=========================

AIBCR3_DCC_CODE_CTRL -- requirements
Module: aibcr3_dcc_code_ctrl

Interface
REQ-001 The block SHALL have parameter CODE_W, default 8, meaning the width of the DCC delay code.
REQ-002 The block SHALL have parameter FILT_W, default 4, meaning each decision window is 2^FILT_W samples.
REQ-003 The block SHALL have parameter SETTLE_CYC, default 7, meaning the number of wait cycles after every code change.
REQ-004 The block SHALL have parameter LOCK_CNT, default 4, meaning the number of tracking direction reversals required for lock.
REQ-005 The block SHALL have port CLKB, input, 1 bit: the clock, also the phase-detector sampling clock.
REQ-006 The block SHALL have port RSTb, input, 1 bit: reset, asynchronous, active-low.
REQ-007 The block SHALL have port dcc_en, input, 1 bit: calibration enable, level-sensitive.
REQ-008 The block SHALL have port t_up, input, 1 bit: phase-detector "increase code" output, synchronous to CLKB.
REQ-009 The block SHALL have port t_down, input, 1 bit: phase-detector "decrease code" output, synchronous to CLKB.
REQ-010 The block SHALL have port code_ovrd_en, input, 1 bit: test override enable.
REQ-011 The block SHALL have port code_ovrd, input, CODE_W bits: the override code value.
REQ-012 The block SHALL have port dcc_code, output, CODE_W bits: the delay code driven to the DCC delay line.
REQ-013 The block SHALL have port dcc_lock, output, 1 bit: calibration locked.
REQ-014 The block SHALL have port dcc_state, output, 3 bits: FSM state for debug (IDLE=0, SETTLE=1, ACCUM=2, DECIDE=3, TRACK_SETTLE=4, TRACK_ACCUM=5, TRACK_DECIDE=6).

Function
REQ-015 The FSM SHALL leave IDLE for SETTLE on the first CLKB edge with dcc_en=1, with the internal code at midscale 2^(CODE_W-1) and step 2^(CODE_W-2).
REQ-016 SETTLE and TRACK_SETTLE SHALL each last exactly SETTLE_CYC cycles, with no samples counted.
REQ-017 ACCUM and TRACK_ACCUM SHALL each last exactly 2^FILT_W cycles, sampling once per cycle.
REQ-018 In ACCUM and TRACK_ACCUM, a sample with t_up=1 and t_down=0 SHALL increment up_cnt; t_up=0 and t_down=1 SHALL increment dn_cnt; t_up==t_down is invalid and SHALL count in neither.
REQ-019 In DECIDE (one cycle), the code SHALL go to code+step if up_cnt>=dn_cnt, otherwise to code-step (a tie resolves up).
REQ-020 In DECIDE, step SHALL then halve.
REQ-021 If step was 1 before the DECIDE, the next state SHALL be TRACK_SETTLE; otherwise it SHALL be SETTLE.
REQ-022 No saturation is needed during the binary search, because its reachable range is 1..2^CODE_W-1.
REQ-023 In TRACK_DECIDE (one cycle), up_cnt>dn_cnt SHALL give code+1, saturating at 2^CODE_W-1.
REQ-024 In TRACK_DECIDE, up_cnt<dn_cnt SHALL give code-1, saturating at 0.
REQ-025 In TRACK_DECIDE, equal counts SHALL leave the code unchanged.
REQ-026 The next state after TRACK_DECIDE SHALL be TRACK_SETTLE.
REQ-027 up_cnt and dn_cnt SHALL clear on entry to each ACCUM and TRACK_ACCUM, and SHALL be FILT_W+1 bits wide (no overflow).
REQ-028 A reversal SHALL be counted when a TRACK_DECIDE move has the opposite direction to the last non-zero move; holds and saturated no-moves SHALL NOT be counted and SHALL NOT update the last direction.
REQ-029 dcc_lock SHALL assert on the cycle after the reversal count reaches LOCK_CNT, and SHALL be sticky while dcc_en=1 and code_ovrd_en=0.
REQ-030 A code change SHALL be visible on dcc_code in the cycle after DECIDE or TRACK_DECIDE.
REQ-031 dcc_en=0 in any state SHALL force, on the next edge: state IDLE, code midscale, step reset, counters 0, reversals 0, dcc_lock 0.
REQ-032 code_ovrd_en=1 SHALL make dcc_code equal code_ovrd, registered with 1-cycle latency.
REQ-033 While code_ovrd_en=1, the FSM and counters SHALL freeze and dcc_lock SHALL be 0.
REQ-034 On release of code_ovrd_en, the FSM SHALL resume from the frozen state using the internal code.
REQ-035 All outputs SHALL be registered, with no combinational path from inputs to outputs.

Reset
REQ-036 RSTb=0 SHALL asynchronously force state IDLE, dcc_code=2^(CODE_W-1) (0x80 at defaults), dcc_lock=0, dcc_state=0, step 2^(CODE_W-2), and all counters 0.
REQ-037 RSTb deassertion SHALL be treated as synchronous to CLKB; the first transition out of IDLE SHALL occur on the first edge after RSTb=1 with dcc_en=1.

Verification (defaults: CODE_W=8, FILT_W=4, SETTLE_CYC=7, LOCK_CNT=4)
REQ-038 Reset: assert RSTb=0 mid-TRACK -> immediately dcc_code=0x80, dcc_lock=0, dcc_state=0.
REQ-039 t_up=1 and t_down=0 constant with dcc_en=1 -> dcc_code steps every 24 cycles through 0xC0, 0xE0, 0xF0, 0xF8, 0xFC, 0xFE, 0xFF, then holds at 0xFF in TRACK with dcc_lock=0.
REQ-040 Phase-detector model t_up=(dcc_code<100) -> binary search ends at 99 or 100; tracking toggles 99/100; dcc_lock=1 after the 4th reversal.
REQ-041 Tie in TRACK (8 up, 8 down per window) -> dcc_code unchanged and reversal count unchanged.
REQ-042 dcc_en dropped mid-ACCUM -> next cycle dcc_state=0, dcc_code=0x80, dcc_lock=0.
REQ-043 All-invalid samples (t_up=t_down=1) for a SAR window -> tie -> code+step.
REQ-044 code_ovrd_en=1 with code_ovrd=0x3C during ACCUM -> dcc_code=0x3C after 1 cycle, dcc_lock=0, dcc_state frozen; on release the FSM resumes.

Source files
------------

// File: rtl/aibcr3_dcc_code_ctrl.sv
// DCC delay-code controller: binary-search calibration, then +/-1 tracking with
// lock after repeated direction reversals, plus a registered test override.
module aibcr3_dcc_code_ctrl #(
  parameter int CODE_W     = 8,
  parameter int FILT_W     = 4,
  parameter int SETTLE_CYC = 7,
  parameter int LOCK_CNT   = 4
) (
  input  logic              CLKB,
  input  logic              RSTb,
  input  logic              dcc_en,
  input  logic              t_up,
  input  logic              t_down,
  input  logic              code_ovrd_en,
  input  logic [CODE_W-1:0] code_ovrd,
  output logic [CODE_W-1:0] dcc_code,
  output logic              dcc_lock,
  output logic [2:0]        dcc_state
);

  localparam int WIN_LEN = 1 << FILT_W;
  localparam int CYC_MAX = (SETTLE_CYC > WIN_LEN) ? SETTLE_CYC : WIN_LEN;
  localparam int CYC_W   = (CYC_MAX > 1) ? $clog2(CYC_MAX) : 1;
  localparam int CNT_W   = FILT_W + 1;
  localparam int REV_W   = $clog2(LOCK_CNT + 1);

  localparam logic [CODE_W-1:0] CODE_MID  = {1'b1, {(CODE_W-1){1'b0}}};
  localparam logic [CODE_W-1:0] STEP_INIT = CODE_MID >> 1;
  localparam logic [CODE_W-1:0] CODE_MAX  = '1;
  localparam logic [CODE_W-1:0] CODE_ONE  = {{(CODE_W-1){1'b0}}, 1'b1};
  localparam logic [CYC_W-1:0]  SETTLE_LAST = CYC_W'(SETTLE_CYC - 1);
  localparam logic [CYC_W-1:0]  WIN_LAST    = CYC_W'(WIN_LEN - 1);
  localparam logic [REV_W-1:0]  REV_LOCK    = REV_W'(LOCK_CNT);

  typedef enum logic [2:0] {
    ST_IDLE         = 3'd0,
    ST_SETTLE       = 3'd1,
    ST_ACCUM        = 3'd2,
    ST_DECIDE       = 3'd3,
    ST_TRACK_SETTLE = 3'd4,
    ST_TRACK_ACCUM  = 3'd5,
    ST_TRACK_DECIDE = 3'd6
  } state_t;

  typedef enum logic [1:0] {
    DIR_NONE = 2'd0,
    DIR_UP   = 2'd1,
    DIR_DN   = 2'd2
  } dir_t;

  state_t             r_state,    w_state_nxt;
  logic [CODE_W-1:0]  r_code,     w_code_nxt;
  logic [CODE_W-1:0]  r_step,     w_step_nxt;
  logic [CYC_W-1:0]   r_cyc,      w_cyc_nxt;
  logic [CNT_W-1:0]   r_up_cnt,   w_up_nxt;
  logic [CNT_W-1:0]   r_dn_cnt,   w_dn_nxt;
  logic [REV_W-1:0]   r_rev_cnt,  w_rev_nxt;
  dir_t               r_last_dir, w_dir_nxt;
  logic               r_lock,     w_lock_nxt;
  logic [CODE_W-1:0]  r_dcc_code, w_out_nxt;

  dir_t               w_move;
  logic               w_samp_up;
  logic               w_samp_dn;

  // Conflicting or absent phase-detector votes count toward neither side.
  assign w_samp_up = t_up & ~t_down;
  assign w_samp_dn = ~t_up & t_down;

  // NOTE: every signal driven here gets a default first so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_code_nxt  = r_code;
    w_step_nxt  = r_step;
    w_cyc_nxt   = r_cyc;
    w_up_nxt    = r_up_cnt;
    w_dn_nxt    = r_dn_cnt;
    w_rev_nxt   = r_rev_cnt;
    w_dir_nxt   = r_last_dir;
    w_lock_nxt  = r_lock | (r_rev_cnt == REV_LOCK);
    w_move      = DIR_NONE;

    if (!dcc_en) begin
      w_state_nxt = ST_IDLE;
      w_code_nxt  = CODE_MID;
      w_step_nxt  = STEP_INIT;
      w_cyc_nxt   = '0;
      w_up_nxt    = '0;
      w_dn_nxt    = '0;
      w_rev_nxt   = '0;
      w_dir_nxt   = DIR_NONE;
      w_lock_nxt  = 1'b0;
    end else if (code_ovrd_en) begin
      // Calibration is frozen in place; only the lock indication drops.
      w_lock_nxt = 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_state_nxt = ST_SETTLE;
          w_code_nxt  = CODE_MID;
          w_step_nxt  = STEP_INIT;
          w_cyc_nxt   = '0;
        end
        ST_SETTLE, ST_TRACK_SETTLE: begin
          if (r_cyc == SETTLE_LAST) begin
            w_state_nxt = (r_state == ST_SETTLE) ? ST_ACCUM : ST_TRACK_ACCUM;
            w_cyc_nxt   = '0;
            w_up_nxt    = '0;
            w_dn_nxt    = '0;
          end else begin
            w_cyc_nxt = r_cyc + 1'b1;
          end
        end
        ST_ACCUM, ST_TRACK_ACCUM: begin
          w_up_nxt = r_up_cnt + {{FILT_W{1'b0}}, w_samp_up};
          w_dn_nxt = r_dn_cnt + {{FILT_W{1'b0}}, w_samp_dn};
          if (r_cyc == WIN_LAST) begin
            w_state_nxt = (r_state == ST_ACCUM) ? ST_DECIDE : ST_TRACK_DECIDE;
            w_cyc_nxt   = '0;
          end else begin
            w_cyc_nxt = r_cyc + 1'b1;
          end
        end
        ST_DECIDE: begin
          // Ties resolve upward; the search range never leaves 1..max.
          w_code_nxt  = (r_up_cnt >= r_dn_cnt) ? (r_code + r_step) : (r_code - r_step);
          w_step_nxt  = r_step >> 1;
          w_cyc_nxt   = '0;
          w_state_nxt = (r_step == CODE_ONE) ? ST_TRACK_SETTLE : ST_SETTLE;
        end
        ST_TRACK_DECIDE: begin
          if ((r_up_cnt > r_dn_cnt) && (r_code != CODE_MAX)) begin
            w_move     = DIR_UP;
            w_code_nxt = r_code + 1'b1;
          end else if ((r_up_cnt < r_dn_cnt) && (r_code != '0)) begin
            w_move     = DIR_DN;
            w_code_nxt = r_code - 1'b1;
          end
          // Only real moves update history; holds and saturated no-moves do not.
          if (w_move != DIR_NONE) begin
            w_dir_nxt = w_move;
            if ((r_last_dir != DIR_NONE) && (r_last_dir != w_move) &&
                (r_rev_cnt != REV_LOCK)) begin
              w_rev_nxt = r_rev_cnt + 1'b1;
            end
          end
          w_cyc_nxt   = '0;
          w_state_nxt = ST_TRACK_SETTLE;
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end

    w_out_nxt = code_ovrd_en ? code_ovrd : w_code_nxt;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge CLKB or negedge RSTb) begin
    if (!RSTb) begin
      r_state    <= ST_IDLE;
      r_code     <= CODE_MID;
      r_step     <= STEP_INIT;
      r_cyc      <= '0;
      r_up_cnt   <= '0;
      r_dn_cnt   <= '0;
      r_rev_cnt  <= '0;
      r_last_dir <= DIR_NONE;
      r_lock     <= 1'b0;
      r_dcc_code <= CODE_MID;
    end else begin
      r_state    <= w_state_nxt;
      r_code     <= w_code_nxt;
      r_step     <= w_step_nxt;
      r_cyc      <= w_cyc_nxt;
      r_up_cnt   <= w_up_nxt;
      r_dn_cnt   <= w_dn_nxt;
      r_rev_cnt  <= w_rev_nxt;
      r_last_dir <= w_dir_nxt;
      r_lock     <= w_lock_nxt;
      r_dcc_code <= w_out_nxt;
    end
  end

  assign dcc_code  = r_dcc_code;
  assign dcc_lock  = r_lock;
  assign dcc_state = r_state;

endmodule
